// File: rtl/taus88_pkg.sv
// Shared constants for the Taus88 combined Tausworthe generator:
// the per-component shift amounts, masks and the default seed.
package taus88_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'd12345;

  // Component 1: b = ((s<<13)^s)>>19 ; s' = ((s & mask)<<12) ^ b
  localparam int unsigned S1_Q = 13;
  localparam int unsigned S1_S = 19;
  localparam int unsigned S1_K = 12;
  localparam logic [31:0] S1_MASK = 32'hFFFF_FFFE;

  localparam int unsigned S2_Q = 2;
  localparam int unsigned S2_S = 25;
  localparam int unsigned S2_K = 4;
  localparam logic [31:0] S2_MASK = 32'hFFFF_FFF8;

  localparam int unsigned S3_Q = 3;
  localparam int unsigned S3_S = 11;
  localparam int unsigned S3_K = 17;
  localparam logic [31:0] S3_MASK = 32'hFFFF_FFF0;

  // Seeds below 2 leave the first component stuck, so they are rejected.
  function automatic logic [31:0] seed_or_default(input logic [31:0] seed,
                                                  input logic [31:0] fallback);
    return (seed < 32'd2) ? fallback : seed;
  endfunction

endpackage

// File: rtl/taus_step.sv
// One Tausworthe component update, purely combinational.
module taus_step #(
  parameter int unsigned Q    = 13,
  parameter int unsigned S    = 19,
  parameter int unsigned K    = 12,
  parameter logic [31:0] MASK = 32'hFFFF_FFFE
) (
  input  logic [31:0] state,
  output logic [31:0] next
);

  logic [31:0] mixed;
  logic [31:0] feedback;
  logic [31:0] masked;

  // Every intermediate is 32 bits so shifted-out bits are discarded.
  assign mixed    = (state << Q) ^ state;
  assign feedback = mixed >> S;
  assign masked   = state & MASK;
  assign next     = (masked << K) ^ feedback;

endmodule

// File: rtl/taus88.sv
// Taus88 generator: three Tausworthe components XORed into one 32-bit word,
// stepping once per clock, with a synchronous reload strobe for S1.
module taus88
  import taus88_pkg::*;
#(
  parameter logic [31:0] S1_INIT = DEFAULT_SEED,
  parameter logic [31:0] S2_INIT = DEFAULT_SEED,
  parameter logic [31:0] S3_INIT = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        re_seed,
  output logic [31:0] rnd
);

  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] s3;
  logic [31:0] s1_step;
  logic [31:0] s2_step;
  logic [31:0] s3_step;

  taus_step #(.Q(S1_Q), .S(S1_S), .K(S1_K), .MASK(S1_MASK)) u_step1 (
    .state (s1),
    .next  (s1_step)
  );

  taus_step #(.Q(S2_Q), .S(S2_S), .K(S2_K), .MASK(S2_MASK)) u_step2 (
    .state (s2),
    .next  (s2_step)
  );

  taus_step #(.Q(S3_Q), .S(S3_S), .K(S3_K), .MASK(S3_MASK)) u_step3 (
    .state (s3),
    .next  (s3_step)
  );

  // A reseed cycle replaces the step entirely: S2 and S3 hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= S1_INIT;
      s2 <= S2_INIT;
      s3 <= S3_INIT;
    end else if (re_seed) begin
      s1 <= seed_or_default(seed, S1_INIT);
    end else begin
      s1 <= s1_step;
      s2 <= s2_step;
      s3 <= s3_step;
    end
  end

  assign rnd = s1 ^ s2 ^ s3;

endmodule

// File: tb/tb_taus88.sv
// Self-checking bench for taus88: directed vector table, hand-written corner
// sequences and a 1000-cycle randomized run against a software Taus88 model.
module tb_taus88;

  logic        clk;
  logic        rst_n;
  logic [31:0] seed;
  logic        re_seed;
  logic [31:0] rnd;

  int checks;
  int failures;

  localparam logic [31:0] INIT = 32'd12345;

  taus88 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (seed),
    .re_seed (re_seed),
    .rnd     (rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Software model: the three component states as a plain array.
  logic [31:0] m [3];
  int unsigned q_tab [3] = '{13, 2, 3};
  int unsigned s_tab [3] = '{19, 25, 11};
  int unsigned k_tab [3] = '{12, 4, 17};
  logic [31:0] mask_tab [3] = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0};

  function automatic logic [31:0] model_out();
    return m[0] ^ m[1] ^ m[2];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) m[c] = INIT;
  endtask

  task automatic model_edge(input logic rs, input logic [31:0] sd);
    logic [31:0] b;
    if (rs) begin
      m[0] = (sd < 2) ? INIT : sd;
    end else begin
      for (int c = 0; c < 3; c++) begin
        b = ((m[c] << q_tab[c]) ^ m[c]) >> s_tab[c];
        m[c] = ((m[c] & mask_tab[c]) << k_tab[c]) ^ b;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: rnd=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Async reset applied between edges; rnd must recover without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", rnd, INIT);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    re_seed = 1'b0;
    #1;
    check("pre_first_edge", rnd, INIT);
  endtask

  // Drive inputs, take one rising edge, compare against model 1 time unit later.
  task automatic cycle(input string name, input logic rs, input logic [31:0] sd);
    re_seed = rs;
    seed    = sd;
    @(posedge clk);
    model_edge(rs, sd);
    #1;
    check(name, rnd, model_out());
    $display("%s re_seed=%0b seed=0x%08h rnd=0x%08h", name, rs, sd, rnd);
  endtask

  typedef struct {
    string       name;
    logic        rs;
    logic [31:0] sd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    re_seed  = 1'b0;
    seed     = '0;
    model_reset();

    vecs[0] = '{"first_step",      1'b0, 32'h0,        32'h63608376};
    vecs[1] = '{"reseed_deadbeef", 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{"reseed_zero",     1'b1, 32'h0,        32'h00003039};
    vecs[3] = '{"reseed_one",      1'b1, 32'h1,        32'h00003039};
    vecs[4] = '{"reseed_two",      1'b1, 32'h2,        32'h00000002};
    vecs[5] = '{"reseed_max",      1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};

    #12;
    check("reset_state", rnd, INIT);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed table: each vector starts from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      re_seed = vecs[i].rs;
      seed    = vecs[i].sd;
      @(posedge clk);
      model_edge(vecs[i].rs, vecs[i].sd);
      #1;
      check(vecs[i].name, rnd, vecs[i].exp);
      $display("%s re_seed=%0b seed=0x%08h rnd=0x%08h", vecs[i].name, vecs[i].rs, vecs[i].sd, rnd);
      cycle("step_after_vec", 1'b0, 32'h0);
      cycle("step_after_vec", 1'b0, 32'h0);
    end

    // re_seed held for several cycles reloads S1 each time, S2/S3 frozen.
    do_reset();
    cycle("hold_step", 1'b0, 32'h0);
    cycle("hold_reseed_a", 1'b1, 32'h12345678);
    cycle("hold_reseed_b", 1'b1, 32'h87654321);
    cycle("hold_reseed_0", 1'b1, 32'h0);
    for (int i = 0; i < 12; i++) cycle("resume_step", 1'b0, 32'h0);
    cycle("mid_reseed", 1'b1, 32'hCAFEBABE);
    for (int i = 0; i < 3; i++) cycle("post_reseed", 1'b0, 32'h0);

    // Mid-sequence async reset, held across an edge with re_seed high.
    #2;
    rst_n   = 1'b0;
    re_seed = 1'b1;
    seed    = 32'h0000FFFF;
    #1;
    model_reset();
    check("mid_async_reset", rnd, INIT);
    @(posedge clk);
    #1;
    check("reset_over_reseed", rnd, INIT);
    #2;
    rst_n   = 1'b1;
    re_seed = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 32'h0);
    #1;
    check("first_edge_after_reset", rnd, 32'h63608376);

    // Randomized long run with the two mandated reseeds plus random ones.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic        rs;
      logic [31:0] sd;
      rs = (i == 300) || (i == 600) || ($urandom_range(0, 49) == 0);
      if (i == 300)      sd = 32'hDEADBEEF;
      else if (i == 600) sd = 32'hCAFEBABE;
      else if ($urandom_range(0, 3) == 0) sd = 32'($urandom_range(0, 1));
      else               sd = $urandom;
      cycle("rand", rs, sd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/taus88.md
TAUS88 -- requirements
Module: taus88

Interface
REQ-001 The block SHALL have parameter S1_INIT, default 32'd12345, reset value of component S1.
REQ-002 The block SHALL have parameter S2_INIT, default 32'd12345, reset value of component S2.
REQ-003 The block SHALL have parameter S3_INIT, default 32'd12345, reset value of component S3.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port seed, input, 32 bits, the new S1 value, sampled only when re_seed is high.
REQ-007 The block SHALL have port re_seed, input, 1 bit, a synchronous load strobe for S1.
REQ-008 The block SHALL have port rnd, output, 32 bits, the current random word.

Function
REQ-009 The block SHALL hold three 32-bit state registers S1, S2 and S3, implementing L'Ecuyer's Taus88 combined Tausworthe generator.
REQ-010 rnd SHALL be combinational, equal to S1 ^ S2 ^ S3 of the current state, with zero latency from the state.
REQ-011 On each clk rising edge with rst_n high and re_seed low, the S1 update SHALL be: b = ((S1<<13)^S1)>>19; S1 <= ((S1 & 32'hFFFFFFFE)<<12) ^ b.
REQ-012 Under the same conditions, the S2 update SHALL be: b = ((S2<<2)^S2)>>25; S2 <= ((S2 & 32'hFFFFFFF8)<<4) ^ b.
REQ-013 Under the same conditions, the S3 update SHALL be: b = ((S3<<3)^S3)>>11; S3 <= ((S3 & 32'hFFFFFFF0)<<17) ^ b.
REQ-014 All shifts SHALL be logical, truncated to 32 bits; no wider intermediates may leak into results.
REQ-015 On a rising edge with re_seed high, S1 SHALL load seed, S2 and S3 SHALL hold their values, and no step SHALL occur that cycle.
REQ-016 If seed < 2 when re_seed is sampled high, S1 SHALL load S1_INIT instead, since a value below 2 would make the S1 component degenerate.
REQ-017 re_seed held high for N cycles SHALL reload S1 every cycle; stepping SHALL resume on the first edge with re_seed low.
REQ-018 rnd SHALL update exactly one step per cycle with no stall or valid handshake; the output is always valid.

Reset
REQ-019 rst_n low SHALL asynchronously set S1=S1_INIT, S2=S2_INIT and S3=S3_INIT, giving rnd = S1_INIT^S2_INIT^S3_INIT (32'd12345 with defaults).
REQ-020 Reset SHALL dominate re_seed.
REQ-021 Reset asserted mid-sequence SHALL discard all state, including any prior reseed.
REQ-022 The first step SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-023 Shift amounts (13/19/12, 2/25/4, 3/11/17), the masks, and the default seed 12345 SHALL live in shared package taus88_pkg.
REQ-024 One sub-module, taus_step, SHALL be used: a combinational single-component update parameterised by (q, s, k-shift, mask), instantiated three times.
REQ-025 The block SHALL have no memories and no multi-cycle paths.

Verification
REQ-026 Reset, then sample rnd before the first edge: rnd SHALL read 32'd12345 (0x00003039).
REQ-027 One edge after reset: S1=0x030380C0, S2=0x00030380, S3=0x60600036, and rnd SHALL read 0x63608376.
REQ-028 Assert re_seed with seed=0xDEADBEEF on the first edge after reset: S2=S3=12345 are held, so rnd SHALL read 0xDEADBEEF, then step normally on following edges.
REQ-029 re_seed with seed=0 or seed=1: S1 SHALL become 12345 and rnd SHALL equal S1_INIT^S2^S3.
REQ-030 Assert rst_n low asynchronously between edges after 10+ steps and a reseed: rnd SHALL return to 0x00003039 immediately, without a clock edge.
REQ-031 Run 1000 cycles against a software Taus88 model seeded identically, including two reseeds (0xDEADBEEF, 0xCAFEBABE): every rnd word SHALL match.
